// File: rtl/alu_arbiter_pkg.sv
// Constants shared by the ALU arbiter slice: opcode width and values, and the
// arbiter FSM state encodings.
package alu_arbiter_pkg;

    localparam int aluOpcodeLen = 4;

    typedef logic [aluOpcodeLen-1:0] aluOpcode_t;

    localparam aluOpcode_t ADD_alu = 4'h0;
    localparam aluOpcode_t SUB_alu = 4'h1;
    localparam aluOpcode_t AND_alu = 4'h2;
    localparam aluOpcode_t OR_alu  = 4'h3;
    localparam aluOpcode_t XOR_alu = 4'h4;
    localparam aluOpcode_t LD_data = 4'h5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } arbState_t;

    // Only arithmetic operations produce a meaningful carry.
    function automatic logic updatesCarry(input aluOpcode_t opc);
        return (opc == ADD_alu) || (opc == SUB_alu);
    endfunction

endpackage

// File: rtl/alu.sv
// Shared 8-bit combinational ALU; carryOut is bit 8 of the add/subtract.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic                    aluEn,
    input  logic [aluOpcodeLen-1:0] aluOpcode,
    input  logic [7:0]              op1,
    input  logic [7:0]              op2,
    output logic [7:0]              aluOut,
    output logic                    carryOut
);

    logic [8:0] wide;

    always_comb begin
        wide = '0;
        if (aluEn) begin
            case (aluOpcode)
                ADD_alu: wide = {1'b0, op1} + {1'b0, op2};
                SUB_alu: wide = {1'b0, op1} - {1'b0, op2};
                AND_alu: wide = {1'b0, op1 & op2};
                OR_alu:  wide = {1'b0, op1 | op2};
                XOR_alu: wide = {1'b0, op1 ^ op2};
                LD_data: wide = {1'b0, op1};
                default: wide = '0;
            endcase
        end
    end

    assign {carryOut, aluOut} = wide;

endmodule

// File: rtl/alu_rr_pick.sv
// Winner selection for the two-requester ALU arbiter, plus the last-served
// pointer that drives round-robin tie breaking.
module alu_rr_pick #(
    parameter bit RR_EN = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic pick
);

    logic lastServed;

    always_comb begin
        pick = req1;
        if (req0 && req1) begin
            pick = RR_EN ? ~lastServed : 1'b0;
        end
    end

    // Starting at "last served = 1" lets requester 0 win the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastServed <= 1'b1;
        end else if (accept) begin
            lastServed <= pick;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: latch the winner's operation,
// run it for one cycle, then strobe done and store the result per requester.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    req1,
    input  logic [aluOpcodeLen-1:0] opc0,
    input  logic [aluOpcodeLen-1:0] opc1,
    input  logic [7:0]              a0,
    input  logic [7:0]              b0,
    input  logic [7:0]              a1,
    input  logic [7:0]              b1,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    done0,
    output logic                    done1,
    output logic [7:0]              res0,
    output logic [7:0]              res1,
    output logic                    cy0,
    output logic                    cy1,
    output logic [aluOpcodeLen-1:0] aluOpcode,
    output logic [7:0]              op1,
    output logic [7:0]              op2,
    output logic                    aluEn,
    input  logic [7:0]              aluOut,
    input  logic                    carryOut,
    output logic                    busy
);

    arbState_t state, nextState;
    logic      accept;
    logic      pick;
    logic      winner;

    assign accept = (state == IDLE) && (req0 || req1);

    alu_rr_pick #(.RR_EN(RR_EN)) rrPick (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .accept (accept),
        .pick   (pick)
    );

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        nextState = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        aluEn     = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) nextState = EXEC;
            end
            EXEC: begin
                aluEn     = 1'b1;
                busy      = 1'b1;
                gnt0      = ~winner;
                gnt1      = winner;
                nextState = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done0     = ~winner;
                done1     = winner;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // NOTE: latched operands and results are reset too, since reset clears every output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            winner    <= 1'b0;
            aluOpcode <= '0;
            op1       <= '0;
            op2       <= '0;
            res0      <= '0;
            res1      <= '0;
            cy0       <= 1'b0;
            cy1       <= 1'b0;
        end else begin
            if (accept) begin
                winner    <= pick;
                aluOpcode <= pick ? opc1 : opc0;
                op1       <= pick ? a1 : a0;
                op2       <= pick ? b1 : b0;
            end
            if (state == EXEC) begin
                if (winner) begin
                    res1 <= aluOut;
                    if (updatesCarry(aluOpcode)) cy1 <= carryOut;
                end else begin
                    res0 <= aluOut;
                    if (updatesCarry(aluOpcode)) cy0 <= carryOut;
                end
            end
        end
    end

endmodule
